stream_to_depend: RTL and testbench
===================================

STREAM_TO_DEPEND -- requirements
Module: stream_to_depend

Interface
- Parameters (name, default, meaning):
REQ-001 DATA_W, 32, stream payload width in bits.
REQ-002 DEPTH, 4, FIFO entries; power of two, minimum 2.
REQ-003 TOK_MAX, 7, saturation limit of the pending dependency-token counter.
- Ports (name, direction, width, meaning):
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 s_valid  in  1  upstream stream beat valid.
REQ-007 s_ready  out  1  block can accept a beat.
REQ-008 s_data  in  DATA_W  upstream payload.
REQ-009 s_last  in  1  beat closes a batch.
REQ-010 m_valid  out  1  downstream stream beat valid.
REQ-011 m_ready  in  1  downstream accepts the beat.
REQ-012 m_data  out  DATA_W  downstream payload.
REQ-013 m_last  out  1  forwarded batch-close flag.
REQ-014 dep_valid  out  1  a completion token is pending for the dependent task.
REQ-015 dep_ready  in  1  dependent task consumes one token.
REQ-016 batch_cnt  out  16  completed batches forwarded; wraps modulo 2^16.
REQ-017 beat_cnt  out  16  beats forwarded in the current batch; saturates at 0xFFFF.

Function
REQ-018 Upstream accept occurs when s_valid && s_ready; {s_data, s_last} are written to FIFO tail.
REQ-019 s_ready SHALL be 1 whenever FIFO occupancy < DEPTH, and is registered (no combinational path from m_ready).
REQ-020 No bypass: a beat accepted in cycle N is first visible on m_* in cycle N+1 at the earliest.
REQ-021 m_valid = FIFO non-empty AND NOT (head.last AND pending == TOK_MAX); m_data/m_last show the FIFO head.
REQ-022 Downstream transfer occurs when m_valid && m_ready and pops the head; m_data/m_last stay stable while m_valid && !m_ready.
REQ-023 Push and pop in the same cycle leave occupancy unchanged; at full, a push is impossible because s_ready = 0.
REQ-024 pending (width clog2(TOK_MAX+1)) increments on each transfer with m_last = 1, and decrements on each dep_valid && dep_ready.
REQ-025 A simultaneous increment and decrement of pending leaves it unchanged; pending never exceeds TOK_MAX nor goes below 0.
REQ-026 dep_valid = (pending != 0).
REQ-027 A transfer with m_last = 1 increments batch_cnt and clears beat_cnt to 0.
REQ-028 A transfer with m_last = 0 increments beat_cnt, saturating at 0xFFFF.
REQ-029 Batch state machine has two states, IDLE (beat_cnt = 0) and IN_BATCH.
REQ-030 IDLE -> IN_BATCH on a non-last transfer; IN_BATCH -> IDLE on a last transfer; a last transfer in IDLE (single-beat batch) stays in IDLE.

Reset
REQ-031 On rst_n low, asynchronously: FIFO empty, pending = 0, batch_cnt = 0, beat_cnt = 0, state = IDLE.
REQ-032 Outputs under reset: s_ready = 0, m_valid = 0, dep_valid = 0, m_data = 0, m_last = 0.
REQ-033 s_ready rises in the first cycle after rst_n deasserts.
REQ-034 Reset mid-batch discards all buffered beats and pending tokens; no partial token is emitted.

Structure
REQ-035 Shared package batchflow_pkg holds the DATA_W default, the token-counter width function and the batch-state enum.
REQ-036 The FIFO is a sub-module stream_fifo (parameters DATA_W+1 and DEPTH; push/pop/full/empty/count); token and counter logic stay in the top.

Verification
REQ-037 Single batch: push data 0x11, 0x22, 0x33 (last on 0x33) with m_ready = 1 and dep_ready = 0 -> three m beats in order; dep_valid = 1; batch_cnt = 1; beat_cnt = 0.
REQ-038 Full: m_ready = 0, push 5 beats -> 4 accepted; s_ready = 0 after the 4th; raising m_ready drains 0x..-ordered data with s_ready back to 1 one cycle after the first pop.
REQ-039 Token saturation: 8 single-beat batches, dep_ready = 0 -> pending = 7; the 8th is held (m_valid = 0); one dep handshake releases it and pending stays 7.
REQ-040 Simultaneous token increment and decrement: last transfer with dep_ready = 1 and pending = 2 -> pending remains 2.
REQ-041 Reset mid-batch: two beats buffered, pending = 3, assert rst_n = 0 -> all outputs and counters at reset values asynchronously, with no further m or dep handshakes.
REQ-042 Wrap: preload a run of 65536 single-beat batches -> batch_cnt wraps 0xFFFF -> 0x0000; a 70000-beat batch holds beat_cnt at 0xFFFF until last.

Source files
------------

// File: rtl/batchflow_pkg.sv
// Shared types and sizing helpers for the batch stream / dependency-token block.
package batchflow_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_BATCH = 1'b1
    } batch_state_e;

    // Bits needed to hold a token count from 0 up to tok_max inclusive.
    function automatic int tok_cnt_w(input int tok_max);
        return (tok_max < 1) ? 1 : $clog2(tok_max + 1);
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Generic FIFO with registered count; latency 1 cycle push-to-head (no bypass).
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
module stream_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             push_dat_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/stream_to_depend.sv
// Buffers a batched stream and emits one dependency token per forwarded batch; latency >=1 cycle.
// Backpressure: s_ready registered from occupancy; batch-closing beats stall while the token counter is full.
module stream_to_depend
    import batchflow_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 4,
    parameter int TOK_MAX = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              dep_valid,
    input  logic              dep_ready,
    output logic [15:0]       batch_cnt,
    output logic [15:0]       beat_cnt
);
    localparam int PW = tok_cnt_w(TOK_MAX);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] TOK_LIM = PW'(TOK_MAX);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W:0]  fifo_head;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count, count_nxt;

    logic             s_ready_q, s_ready_d;
    logic [PW-1:0]    pending_q, pending_d;
    logic [15:0]      batch_cnt_q, batch_cnt_d;
    logic [15:0]      beat_cnt_q, beat_cnt_d;
    batch_state_e     state_q, state_d;

    logic push, pop, head_last, last_xfer, beat_xfer, dep_take;

    assign push      = s_valid && s_ready_q && !fifo_full;
    assign head_last = fifo_head[DATA_W];
    assign m_valid   = !fifo_empty && !(head_last && (pending_q == TOK_LIM));
    assign pop       = m_valid && m_ready;
    assign last_xfer = pop && head_last;
    assign beat_xfer = pop && !head_last;
    assign dep_valid = (pending_q != '0);
    assign dep_take  = dep_valid && dep_ready;

    // Gate the head so the payload reads zero whenever nothing is buffered (including reset).
    assign m_data    = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    assign m_last    = !fifo_empty && head_last;
    assign s_ready   = s_ready_q;
    assign batch_cnt = batch_cnt_q;
    assign beat_cnt  = beat_cnt_q;

    stream_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i ({s_last, s_data}),
        .pop_i      (pop),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop)      count_nxt = fifo_count + 1'b1;
        else if (!push && pop) count_nxt = fifo_count - 1'b1;
        s_ready_d = (count_nxt < DEPTH_C);
    end

    // A closing transfer is only possible below TOK_MAX, so increment cannot overflow.
    always_comb begin
        pending_d = pending_q;
        case ({last_xfer, dep_take})
            2'b10:   pending_d = pending_q + 1'b1;
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (beat_xfer) state_d = ST_IN_BATCH;
            ST_IN_BATCH: if (last_xfer) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        batch_cnt_d = batch_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        if (last_xfer) begin
            batch_cnt_d = batch_cnt_q + 16'd1;
            beat_cnt_d  = '0;
        end else if (beat_xfer) begin
            case (state_q)
                ST_IDLE:  beat_cnt_d = 16'd1;
                default:  beat_cnt_d = (beat_cnt_q == 16'hFFFF) ? 16'hFFFF : beat_cnt_q + 16'd1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready_q   <= 1'b0;
            pending_q   <= '0;
            batch_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            s_ready_q   <= s_ready_d;
            pending_q   <= pending_d;
            batch_cnt_q <= batch_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_stream_to_depend.sv
// Bench for stream_to_depend: directed scenarios plus random traffic against a queue-based reference model.
module tb_stream_to_depend;
    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int TOK_MAX = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0, dep_ready = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, m_valid, m_last, dep_valid;
    logic [DW-1:0] m_data;
    logic [15:0]   batch_cnt, beat_cnt;

    always #5 clk = ~clk;

    stream_to_depend #(.DATA_W(DW), .DEPTH(DEPTH), .TOK_MAX(TOK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .dep_valid(dep_valid), .dep_ready(dep_ready),
        .batch_cnt(batch_cnt), .beat_cnt(beat_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: buffered beats as {last,data}, token count, batch/beat counters.
    logic [DW:0]   mq[$];
    int            pend = 0;
    logic [15:0]   bcnt = '0, btcnt = '0;

    // Handshakes actually observed on the DUT ports.
    int            dep_hs = 0, m_hs = 0;
    logic [DW-1:0] got[$];

    task automatic cycle(input logic sv, input logic [DW-1:0] sd, input logic sl,
                         input logic mr, input logic dr);
        logic exp_sr, exp_mv, exp_dv, pushed, popped, lst;
        logic [DW:0] head;
        @(negedge clk);
        head   = (mq.size() != 0) ? mq[0] : '0;
        exp_sr = (mq.size() < DEPTH);
        exp_mv = (mq.size() != 0) && !(head[DW] && pend == TOK_MAX);
        exp_dv = (pend != 0);
        n_tests++;
        if (s_ready !== exp_sr) begin n_fail++; $display("FAIL s_ready: got %b want %b t=%0t", s_ready, exp_sr, $time); end
        n_tests++;
        if (m_valid !== exp_mv) begin n_fail++; $display("FAIL m_valid: got %b want %b t=%0t", m_valid, exp_mv, $time); end
        n_tests++;
        if (dep_valid !== exp_dv) begin n_fail++; $display("FAIL dep_valid: got %b want %b t=%0t", dep_valid, exp_dv, $time); end
        n_tests++;
        if (batch_cnt !== bcnt) begin n_fail++; $display("FAIL batch_cnt: got %h want %h t=%0t", batch_cnt, bcnt, $time); end
        n_tests++;
        if (beat_cnt !== btcnt) begin n_fail++; $display("FAIL beat_cnt: got %h want %h t=%0t", beat_cnt, btcnt, $time); end
        if (exp_mv) begin
            n_tests++;
            if ({m_last, m_data} !== head) begin
                n_fail++;
                $display("FAIL m_beat: got last=%b data=%h want last=%b data=%h t=%0t",
                         m_last, m_data, head[DW], head[DW-1:0], $time);
            end
        end
        if (dep_valid && dr) dep_hs++;
        if (m_valid && mr) begin m_hs++; got.push_back(m_data); end
        s_valid = sv; s_data = sd; s_last = sl; m_ready = mr; dep_ready = dr;
        pushed = sv && exp_sr;
        popped = mr && exp_mv;
        lst    = popped && head[DW];
        if (popped) begin
            void'(mq.pop_front());
            if (head[DW]) begin
                bcnt  = bcnt + 16'd1;
                btcnt = '0;
            end else if (btcnt != 16'hFFFF) begin
                btcnt = btcnt + 16'd1;
            end
        end
        if (pushed) mq.push_back({sl, sd});
        pend = pend + (lst ? 1 : 0) - ((dr && exp_dv) ? 1 : 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; dep_ready = 1'b0; s_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mq.delete(); pend = 0; bcnt = '0; btcnt = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({s_ready, m_valid, dep_valid, m_last} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {s_ready, m_valid, dep_valid, m_last});
        end
        n_tests++;
        if (m_data !== '0 || batch_cnt !== '0 || beat_cnt !== '0) begin
            n_fail++; $display("FAIL reset_vals: got data=%h batch=%h beat=%h want 0", m_data, batch_cnt, beat_cnt);
        end
        rst_n = 1'b1;
        cycle(0, '0, 0, 0, 0);
        n_tests++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rise: s_ready got %b want 1", s_ready); end
    endtask

    task automatic test_single_batch();
        got.delete();
        cycle(1, DW'(32'h11), 0, 1, 0);
        cycle(1, DW'(32'h22), 0, 1, 0);
        cycle(1, DW'(32'h33), 1, 1, 0);
        repeat (3) cycle(0, '0, 0, 1, 0);
        n_tests++;
        if (got.size() != 3 || got[0] !== DW'(32'h11) || got[1] !== DW'(32'h22) || got[2] !== DW'(32'h33)) begin
            n_fail++; $display("FAIL single_order: got %0d beats want 3 in order 11,22,33", got.size());
        end
        n_tests++;
        if (dep_valid !== 1'b1 || batch_cnt !== 16'd1 || beat_cnt !== 16'd0) begin
            n_fail++; $display("FAIL single_cnt: got dep=%b batch=%h beat=%h want 1,0001,0000", dep_valid, batch_cnt, beat_cnt);
        end
    endtask

    task automatic test_full();
        got.delete();
        for (int i = 0; i < 5; i++) cycle(1, DW'(32'hA1 + i), (i == 3), 0, 0);
        cycle(0, '0, 0, 0, 0);
        n_tests++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL full_sready: got %b want 0", s_ready); end
        cycle(0, '0, 0, 1, 0);
        cycle(0, '0, 0, 1, 0);
        n_tests++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL full_reopen: got %b want 1", s_ready); end
        repeat (4) cycle(0, '0, 0, 1, 0);
        n_tests++;
        if (got.size() != 4 || got[0] !== DW'(32'hA1) || got[1] !== DW'(32'hA2) ||
            got[2] !== DW'(32'hA3) || got[3] !== DW'(32'hA4)) begin
            n_fail++; $display("FAIL full_drain: got %0d beats want 4 (A1..A4)", got.size());
        end
    endtask

    task automatic test_token_sat();
        int m0, d0;
        m0 = m_hs;
        for (int i = 0; i < 8; i++) cycle(1, DW'(i), 1, 1, 0);
        repeat (3) cycle(0, '0, 0, 1, 0);
        n_tests++;
        if (m_hs - m0 != 7 || m_valid !== 1'b0) begin
            n_fail++; $display("FAIL tok_hold: got %0d xfers m_valid=%b want 7 and 0", m_hs - m0, m_valid);
        end
        cycle(0, '0, 0, 1, 1);
        repeat (3) cycle(0, '0, 0, 1, 0);
        n_tests++;
        if (m_hs - m0 != 8) begin n_fail++; $display("FAIL tok_release: got %0d xfers want 8", m_hs - m0); end
        d0 = dep_hs;
        repeat (10) cycle(0, '0, 0, 0, 1);
        n_tests++;
        if (dep_hs - d0 != 7) begin n_fail++; $display("FAIL tok_count: got %0d tokens want 7", dep_hs - d0); end
    endtask

    task automatic test_simultaneous();
        int d0;
        cycle(1, DW'(32'h1), 1, 1, 0);
        cycle(1, DW'(32'h2), 1, 1, 0);
        repeat (2) cycle(0, '0, 0, 1, 0);
        cycle(1, DW'(32'h55), 1, 0, 0);
        cycle(0, '0, 0, 1, 1);
        cycle(0, '0, 0, 0, 0);
        n_tests++;
        if (batch_cnt !== 16'd3) begin n_fail++; $display("FAIL simul_batch: got %h want 0003", batch_cnt); end
        d0 = dep_hs;
        repeat (6) cycle(0, '0, 0, 0, 1);
        n_tests++;
        if (dep_hs - d0 != 2) begin n_fail++; $display("FAIL simul_pending: got %0d tokens want 2", dep_hs - d0); end
    endtask

    task automatic test_reset_mid();
        int d0, m0;
        for (int i = 0; i < 3; i++) cycle(1, DW'(i), 1, 1, 0);
        repeat (2) cycle(0, '0, 0, 1, 0);
        cycle(1, DW'(32'hB1), 0, 0, 0);
        cycle(1, DW'(32'hB2), 0, 0, 0);
        cycle(0, '0, 0, 0, 0);
        n_tests++;
        if (dep_valid !== 1'b1 || m_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup: got dep=%b m_valid=%b want 1,1", dep_valid, m_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({s_ready, m_valid, dep_valid, m_last} !== 4'b0000 || m_data !== '0 ||
            batch_cnt !== '0 || beat_cnt !== '0) begin
            n_fail++; $display("FAIL mid_async: got flags=%b data=%h batch=%h beat=%h want all 0",
                               {s_ready, m_valid, dep_valid, m_last}, m_data, batch_cnt, beat_cnt);
        end
        s_valid = 1'b1; m_ready = 1'b1; dep_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (m_valid !== 1'b0 || dep_valid !== 1'b0) begin
                n_fail++; $display("FAIL mid_held: got m_valid=%b dep_valid=%b want 0,0", m_valid, dep_valid);
            end
        end
        s_valid = 1'b0; m_ready = 1'b0; dep_ready = 1'b0;
        rst_n = 1'b1;
        mq.delete(); pend = 0; bcnt = '0; btcnt = '0;
        d0 = dep_hs; m0 = m_hs;
        repeat (3) cycle(0, '0, 0, 1, 1);
        n_tests++;
        if (dep_hs != d0 || m_hs != m0) begin
            n_fail++; $display("FAIL mid_leak: got %0d tokens %0d beats want 0,0", dep_hs - d0, m_hs - m0);
        end
    endtask

    task automatic test_wrap();
        cycle(0, '0, 0, 0, 0);
        force dut.batch_cnt_q = 16'hFFFE;
        #1 release dut.batch_cnt_q;
        bcnt = 16'hFFFE;
        for (int i = 0; i < 4; i++) cycle(1, $urandom, 1, 1, 1);
        repeat (2) cycle(0, '0, 0, 1, 1);
        n_tests++;
        if (batch_cnt !== 16'h0002) begin n_fail++; $display("FAIL batch_wrap: got %h want 0002", batch_cnt); end
        cycle(1, $urandom, 0, 1, 1);
        cycle(0, '0, 0, 1, 1);
        cycle(0, '0, 0, 0, 0);
        force dut.beat_cnt_q = 16'hFFFD;
        #1 release dut.beat_cnt_q;
        btcnt = 16'hFFFD;
        for (int i = 0; i < 4; i++) cycle(1, $urandom, 0, 1, 1);
        repeat (2) cycle(0, '0, 0, 1, 1);
        n_tests++;
        if (beat_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL beat_sat: got %h want FFFF", beat_cnt); end
        cycle(1, $urandom, 1, 1, 1);
        repeat (2) cycle(0, '0, 0, 1, 1);
        n_tests++;
        if (beat_cnt !== 16'h0000 || batch_cnt !== 16'h0003) begin
            n_fail++; $display("FAIL sat_close: got beat=%h batch=%h want 0000,0003", beat_cnt, batch_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++)
            cycle(($urandom_range(3) != 0), $urandom, ($urandom_range(3) == 0),
                  ($urandom_range(3) != 0), ($urandom_range(2) == 0));
        repeat (12) cycle(0, '0, 0, 1, 1);
    endtask

    initial begin
        test_reset();
        test_single_batch();
        apply_reset();
        test_full();
        apply_reset();
        test_token_sat();
        apply_reset();
        test_simultaneous();
        apply_reset();
        test_reset_mid();
        apply_reset();
        test_wrap();
        apply_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
